instr_fetch_seq: RTL

//  Parametrised successor to the single-register instruction decoder.

---
 rtl/msp430_pkg.sv | 79 +++++++
 rtl/instr_fetch_seq_if.sv | 34 +++
 rtl/instr_fetch_seq_dec_fifo.sv | 60 ++++++
 rtl/instr_fetch_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/msp430_pkg.sv
// Shared MSP430 decode definitions for the instruction fetch sequencer:
// format codes, opcode field positions, special register numbers and the
// extension-word decode helpers.
// Optional feature macro: CGEN_DECODE_EN (constant-generator aware src decode).
package msp430_pkg;

    typedef enum logic [1:0] {
        FMT_I   = 2'd0,  // double operand
        FMT_II  = 2'd1,  // single operand
        FMT_J   = 2'd2,  // conditional / unconditional jump
        FMT_ILL = 2'd3   // anything else
    } fmt_e;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_SRC = 2'd1,
        FETCH_DST = 2'd2,
        DRAIN     = 2'd3
    } fetch_state_e;

    // Complete instruction bundle as stored in the decoded FIFO (PC kept
    // separately because its width is a module parameter).
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] ext_src;
        logic [15:0] ext_dst;
        logic [1:0]  nwords;
        fmt_e        fmt;
    } bundle_t;

    // Opcode word field positions
    localparam int AS_MSB    = 5;
    localparam int AS_LSB    = 4;
    localparam int AD_BIT    = 7;
    localparam int RS_I_MSB  = 11;   // FMT_I source register
    localparam int RS_I_LSB  = 8;
    localparam int RS_II_MSB = 3;    // FMT_II operand register
    localparam int RS_II_LSB = 0;

    // Addressing modes that may pull an extension word
    localparam logic [1:0] AS_INDEXED = 2'b01;
    localparam logic [1:0] AS_AUTOINC = 2'b11;

    // Special register numbers
    localparam logic [3:0] REG_PC  = 4'd0;
    localparam logic [3:0] REG_CG1 = 4'd2;   // SR doubles as constant generator 1
    localparam logic [3:0] REG_CG2 = 4'd3;

    function automatic fmt_e decode_fmt(input logic [15:0] w);
        fmt_e f;
        if (w[15:12] >= 4'h4)         f = FMT_I;
        else if (w[15:13] == 3'b001)  f = FMT_J;
        else if (w[15:10] == 6'b000100) f = FMT_II;
        else                          f = FMT_ILL;
        return f;
    endfunction

    function automatic logic src_word_needed(input logic [15:0] w, input fmt_e f);
        logic [1:0] as_f;
        logic [3:0] rs;
        logic       need;
        as_f = w[AS_MSB:AS_LSB];
        rs   = (f == FMT_I) ? w[RS_I_MSB:RS_I_LSB] : w[RS_II_MSB:RS_II_LSB];
        need = (f == FMT_I || f == FMT_II) &&
               (as_f == AS_INDEXED || (as_f == AS_AUTOINC && rs == REG_PC));
`ifdef CGEN_DECODE_EN
        // R3 in any mode and R2 in modes 10/11 produce constants; R2 with
        // mode 01 is absolute addressing and keeps its word.
        if (rs == REG_CG2) need = 1'b0;
        if (rs == REG_CG1 && as_f[1]) need = 1'b0;
`endif
        return need;
    endfunction

    function automatic logic dst_word_needed(input logic [15:0] w, input fmt_e f);
        return (f == FMT_I) && w[AD_BIT];
    endfunction

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Bus bundle of the instruction fetch sequencer: ROM read port, redirect
// input and decoded-instruction valid/ready output.
interface instr_fetch_seq_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;
    logic              dec_valid;
    logic              dec_ready;
    logic [15:0]       dec_instr;
    logic [15:0]       dec_ext_src;
    logic [15:0]       dec_ext_dst;
    logic [1:0]        dec_nwords;
    logic [1:0]        dec_fmt;
    logic [ADDR_W-1:0] dec_pc;

    // Fetch unit side
    modport master (
        output mem_req, mem_addr, dec_valid, dec_instr, dec_ext_src,
               dec_ext_dst, dec_nwords, dec_fmt, dec_pc,
        input  mem_ack, mem_rdata, redir_valid, redir_pc, dec_ready
    );

    // Memory / execute-control side
    modport slave (
        input  mem_req, mem_addr, dec_valid, dec_instr, dec_ext_src,
               dec_ext_dst, dec_nwords, dec_fmt, dec_pc,
        output mem_ack, mem_rdata, redir_valid, redir_pc, dec_ready
    );
endinterface

// File: rtl/instr_fetch_seq_dec_fifo.sv
// dec_fifo: synchronous FIFO with flush and count-based full/empty.
// Head data reads as zero while empty so downstream fields idle at 0.
module dec_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_en, rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the FIFO over push/pop
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; empty gates the read data,
        // so stale entries are never visible.
        if (wr_en) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: owns the fetch PC, reads the opcode word plus 0-2
// extension words from ROM, and queues complete bundles in dec_fifo for the
// execute control. Redirect flushes the queue and restarts fetch; a request
// still waiting for its ack at redirect time is drained first.
// Optional feature macro: CGEN_DECODE_EN (see msp430_pkg).
module instr_fetch_seq
    import msp430_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input logic               clk,
    input logic               rst,
    instr_fetch_seq_if.master bus
);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(2);
    localparam int                FIFO_W     = ADDR_W + $bits(bundle_t);

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc;          // address of the word being requested
    logic [ADDR_W-1:0] redir_tgt;   // restart address held while draining
    logic [ADDR_W-1:0] op_pc;       // address of the current opcode word
    logic [15:0]       instr_q;
    logic [15:0]       ext_src_q;
    fmt_e              fmt_q;
    logic              need_src_q, need_dst_q;

    fmt_e              op_fmt;
    logic              op_need_src, op_need_dst;
    logic              mem_req, accept;
    logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    bundle_t           push_bundle, head;
    logic [ADDR_W-1:0] push_pc, head_pc;
    logic [FIFO_W-1:0] fifo_rdata;

    // Opcode decode straight off the read bus, used only in FETCH_OP
    assign op_fmt      = decode_fmt(bus.mem_rdata);
    assign op_need_src = src_word_needed(bus.mem_rdata, op_fmt);
    assign op_need_dst = dst_word_needed(bus.mem_rdata, op_fmt);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH_OP;
        else     state <= state_nxt;
    end

    // Next state, memory request and bundle push
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned and infers a latch.
        state_nxt   = state;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;
        push_pc     = op_pc;
        push_bundle = '{instr: instr_q, ext_src: ext_src_q, ext_dst: 16'h0000,
                        nwords: 2'd1, fmt: fmt_q};

        // A full FIFO only holds back the start of a new instruction
        mem_req = (state == FETCH_OP) ? !fifo_full : 1'b1;
        if (rst) mem_req = 1'b0;
        accept = mem_req && bus.mem_ack;

        case (state)
            FETCH_OP: begin
                if (accept) begin
                    if (op_need_src) begin
                        state_nxt = FETCH_SRC;
                    end else if (op_need_dst) begin
                        state_nxt = FETCH_DST;
                    end else begin
                        fifo_push           = 1'b1;
                        push_pc             = pc;
                        push_bundle.instr   = bus.mem_rdata;
                        push_bundle.ext_src = 16'h0000;
                        push_bundle.fmt     = op_fmt;
                    end
                end
            end
            FETCH_SRC: begin
                if (accept) begin
                    if (need_dst_q) begin
                        state_nxt = FETCH_DST;
                    end else begin
                        state_nxt           = FETCH_OP;
                        fifo_push           = 1'b1;
                        push_bundle.ext_src = bus.mem_rdata;
                        push_bundle.nwords  = 2'd2;
                    end
                end
            end
            FETCH_DST: begin
                if (accept) begin
                    state_nxt          = FETCH_OP;
                    fifo_push          = 1'b1;
                    push_bundle.ext_dst = bus.mem_rdata;
                    push_bundle.nwords = need_src_q ? 2'd3 : 2'd2;
                end
            end
            DRAIN: begin
                // The ack here belongs to the request cancelled by redirect
                if (accept) state_nxt = FETCH_OP;
            end
            default: state_nxt = FETCH_OP;
        endcase

        // Redirect overrides everything: drop partial bundle, flush queue
        if (bus.redir_valid) begin
            fifo_flush = 1'b1;
            fifo_push  = 1'b0;
            state_nxt  = (mem_req && !bus.mem_ack) ? DRAIN : FETCH_OP;
        end
    end

    // Fetch PC and partial-bundle registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC & ALIGN_MASK;
            redir_tgt  <= '0;
            op_pc      <= '0;
            instr_q    <= '0;
            ext_src_q  <= '0;
            fmt_q      <= FMT_I;
            need_src_q <= 1'b0;
            need_dst_q <= 1'b0;
        end else if (bus.redir_valid) begin
            // While draining, mem_addr must stay on the outstanding request
            if (state_nxt == DRAIN) redir_tgt <= bus.redir_pc & ALIGN_MASK;
            else                    pc        <= bus.redir_pc & ALIGN_MASK;
        end else if (accept) begin
            if (state == DRAIN) begin
                pc <= redir_tgt;
            end else begin
                pc <= pc + PC_STEP;
                case (state)
                    FETCH_OP: begin
                        instr_q    <= bus.mem_rdata;
                        op_pc      <= pc;
                        fmt_q      <= op_fmt;
                        need_src_q <= op_need_src;
                        need_dst_q <= op_need_dst;
                        ext_src_q  <= '0;
                    end
                    FETCH_SRC: ext_src_q <= bus.mem_rdata;
                    default: ;
                endcase
            end
        end
    end

    assign fifo_pop = !fifo_empty && bus.dec_ready;

    dec_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_dec_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata ({push_pc, push_bundle}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_pc, head} = fifo_rdata;

    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = pc;
    assign bus.dec_valid   = !fifo_empty;
    assign bus.dec_instr   = head.instr;
    assign bus.dec_ext_src = head.ext_src;
    assign bus.dec_ext_dst = head.ext_dst;
    assign bus.dec_nwords  = head.nwords;
    assign bus.dec_fmt     = head.fmt;
    assign bus.dec_pc      = head_pc;
endmodule
